// File: rtl/trigger_chain_cfg_pkg.sv
// Shared types and constants for the trigger-chain configuration sequencer.
package trigger_chain_cfg_pkg;

    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned CH_IDX_W   = $clog2(NUM_CH);
    localparam int unsigned CH_ADR_LSB = 8;
    localparam logic [3:0]  WB_SEL_ALL = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StIssue,
        StVerify,
        StDone
    } state_e;

    function automatic logic [NUM_CH-1:0] ch_bit(input logic [CH_IDX_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/trigger_chain_cfg_prio_enc.sv
// Lowest-set-bit priority encoder over the remaining channel mask.
module trigger_chain_cfg_prio_enc
    import trigger_chain_cfg_pkg::*;
(
    input  logic [NUM_CH-1:0]   i_mask,
    output logic                o_found,
    output logic [CH_IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = |i_mask;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = CH_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trigger_chain_cfg_sequencer.sv
// Wishbone master writing one config word to each selected trigger-chain channel.
// Define TRIG_CFG_READBACK_EN to verify every acked write with a read of the same address.
module trigger_chain_cfg_sequencer
    import trigger_chain_cfg_pkg::*;
#(
    parameter int unsigned ADR_W     = 22,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [NUM_CH-1:0] req_chmask_i,
    input  logic [7:0]        req_offset_i,
    input  logic [31:0]       req_dat_i,
    output logic              done_o,
    output logic              err_o,
    output logic [NUM_CH-1:0] err_chmask_o,
    output logic              wb_m_cyc_o,
    output logic              wb_m_stb_o,
    output logic              wb_m_we_o,
    output logic [ADR_W-1:0]  wb_m_adr_o,
    output logic [31:0]       wb_m_dat_o,
    output logic [3:0]        wb_m_sel_o,
    input  logic [31:0]       wb_m_dat_i,
    input  logic              wb_m_ack_i,
    input  logic              wb_m_err_i,
    input  logic              wb_m_rty_i
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e              r_state, w_state_nxt;
    logic [NUM_CH-1:0]   r_mask, w_mask_nxt;
    logic [NUM_CH-1:0]   r_errmask, w_errmask_nxt;
    logic [CH_IDX_W-1:0] r_ch, w_ch_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic [RETRY_W-1:0]  r_retry, w_retry_nxt;
    logic                r_rd, w_rd_nxt;
    logic [7:0]          r_offset;
    logic [31:0]         r_dat;
    logic                w_accept, w_fin, w_fail, w_bus, w_found;
    logic [CH_IDX_W-1:0] w_idx;
    logic [NUM_CH-1:0]   w_mask_left;

`ifndef TRIG_CFG_READBACK_EN
    logic w_unused_dat;
    assign w_unused_dat = ^wb_m_dat_i;
`endif

    trigger_chain_cfg_prio_enc u_prio_enc (
        .i_mask  (r_mask),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_accept = (r_state == StIdle) && req_valid_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_errmask_nxt = r_errmask;
        w_ch_nxt      = r_ch;
        w_tmo_nxt     = r_tmo;
        w_retry_nxt   = r_retry;
        w_rd_nxt      = r_rd;
        w_fin         = 1'b0;
        w_fail        = 1'b0;
        w_mask_left   = r_mask & ~ch_bit(r_ch);
        case (r_state)
            StIdle: begin
                if (req_valid_i) begin
                    w_mask_nxt    = req_chmask_i;
                    w_errmask_nxt = '0;
                    w_retry_nxt   = '0;
                    w_rd_nxt      = 1'b0;
                    w_state_nxt   = (|req_chmask_i) ? StScan : StDone;
                end
            end
            StScan: begin
                w_tmo_nxt = '0;
                if (w_found) begin
                    w_ch_nxt    = w_idx;
                    w_state_nxt = r_rd ? StVerify : StIssue;
                end else begin
                    w_state_nxt = StDone;
                end
            end
            StIssue, StVerify: begin
                if (wb_m_err_i) begin
                    w_fail = 1'b1;
                end else if (wb_m_ack_i) begin
`ifdef TRIG_CFG_READBACK_EN
                    if (!r_rd) begin
                        w_rd_nxt    = 1'b1;
                        w_retry_nxt = '0;
                        w_state_nxt = StScan;
                    end else begin
                        w_fin  = 1'b1;
                        w_fail = (wb_m_dat_i != r_dat);
                    end
`else
                    w_fin = 1'b1;
`endif
                end else if (wb_m_rty_i) begin
                    if (r_retry >= RETRY_W'(MAX_RETRY)) begin
                        w_fail = 1'b1;
                    end else begin
                        // Re-entering via SCAN gives the one idle bus cycle before reissue.
                        w_retry_nxt = r_retry + RETRY_W'(1);
                        w_state_nxt = StScan;
                    end
                end else if (r_tmo >= TMO_W'(TIMEOUT - 1)) begin
                    w_fail = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (w_fin || w_fail) begin
            w_mask_nxt  = w_mask_left;
            w_retry_nxt = '0;
            w_rd_nxt    = 1'b0;
            w_state_nxt = (|w_mask_left) ? StScan : StDone;
            if (w_fail) begin
                w_errmask_nxt = r_errmask | ch_bit(r_ch);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= StIdle;
            r_mask    <= '0;
            r_errmask <= '0;
            r_ch      <= '0;
            r_tmo     <= '0;
            r_retry   <= '0;
            r_rd      <= 1'b0;
            r_offset  <= '0;
            r_dat     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_errmask <= w_errmask_nxt;
            r_ch      <= w_ch_nxt;
            r_tmo     <= w_tmo_nxt;
            r_retry   <= w_retry_nxt;
            r_rd      <= w_rd_nxt;
            if (w_accept) begin
                r_offset <= req_offset_i;
                r_dat    <= req_dat_i;
            end
        end
    end

    // Bus outputs decode straight from state so reset drops cyc/stb without waiting for a clock.
    assign w_bus        = (r_state == StIssue) || (r_state == StVerify);
    assign wb_m_cyc_o   = w_bus;
    assign wb_m_stb_o   = w_bus;
    assign wb_m_we_o    = (r_state == StIssue);
    assign wb_m_adr_o   = w_bus ? ((ADR_W'(r_ch) << CH_ADR_LSB) | ADR_W'(r_offset)) : '0;
    assign wb_m_dat_o   = w_bus ? r_dat : '0;
    assign wb_m_sel_o   = w_bus ? WB_SEL_ALL : 4'h0;
    assign req_ready_o  = (r_state == StIdle);
    assign done_o       = (r_state == StDone);
    assign err_o        = done_o && (|r_errmask);
    assign err_chmask_o = r_errmask;

endmodule

// File: tb/tb_trigger_chain_cfg_sequencer.sv
// Directed self-checking bench for trigger_chain_cfg_sequencer with a behavioural WB target.
module tb_trigger_chain_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, done, err;
    logic [7:0]  req_chmask, req_offset, err_chmask;
    logic [31:0] req_dat;
    logic        cyc, stb, we, ack, wb_err, rty;
    logic [21:0] adr;
    logic [31:0] dat_o, dat_i;
    logic [3:0]  sel;

    logic [7:0]  s_err_ch, s_bad_rd;
    logic        s_silent;
    int unsigned s_rty_n, s_rty_base;
    logic [31:0] cur_dat;

    int unsigned rty_given, cyc_cnt, wr_hs, done_cnt;
    logic [21:0] wr_log[$];
    logic [31:0] wr_dat_log[$];

    int n_checks = 0;
    int n_err = 0;
    bit          d_got;
    logic        d_err;
    logic [7:0]  d_mask;
    int          b, c0, h0, n0;

    always #5 clk = ~clk;

    trigger_chain_cfg_sequencer #(
        .ADR_W     (22),
        .TIMEOUT   (255),
        .MAX_RETRY (3)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_chmask_i (req_chmask),
        .req_offset_i (req_offset),
        .req_dat_i    (req_dat),
        .done_o       (done),
        .err_o        (err),
        .err_chmask_o (err_chmask),
        .wb_m_cyc_o   (cyc),
        .wb_m_stb_o   (stb),
        .wb_m_we_o    (we),
        .wb_m_adr_o   (adr),
        .wb_m_dat_o   (dat_o),
        .wb_m_sel_o   (sel),
        .wb_m_dat_i   (dat_i),
        .wb_m_ack_i   (ack),
        .wb_m_err_i   (wb_err),
        .wb_m_rty_i   (rty)
    );

    // Zero-wait target: err on selected write channels, a budget of rty on writes, else ack.
    always_comb begin
        ack    = 1'b0;
        wb_err = 1'b0;
        rty    = 1'b0;
        dat_i  = 32'h0;
        if (cyc && stb && !s_silent) begin
            if (we && s_err_ch[adr[10:8]]) begin
                wb_err = 1'b1;
            end else if (we && ((rty_given - s_rty_base) < s_rty_n)) begin
                rty = 1'b1;
            end else begin
                ack = 1'b1;
            end
            dat_i = s_bad_rd[adr[10:8]] ? 32'h0 : cur_dat;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (cyc) cyc_cnt <= cyc_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (cyc && stb && we && (ack || wb_err || rty)) begin
                wr_hs <= wr_hs + 1;
                wr_log.push_back(adr);
                wr_dat_log.push_back(dat_o);
                if (rty) rty_given <= rty_given + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] m, input logic [7:0] o, input logic [31:0] d);
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_chmask = m;
        req_offset = o;
        req_dat    = d;
        cur_dat    = d;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Looks at the current cycle first, so a done_o one cycle after accept is caught.
    task automatic wait_done(input string tag, input int max);
        d_got  = 1'b0;
        d_err  = 1'b0;
        d_mask = 8'h0;
        for (int i = 0; i < max; i++) begin
            if (done) begin
                d_got  = 1'b1;
                d_err  = err;
                d_mask = err_chmask;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, {31'b0, d_got}, 32'd1);
        if (d_got) begin
            @(negedge clk);
            chk({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
            chk({tag, "_mask_held"}, {24'b0, err_chmask}, {24'b0, d_mask});
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_chmask = 8'h0; req_offset = 8'h0; req_dat = 32'h0;
        s_err_ch = 8'h0; s_bad_rd = 8'h0; s_silent = 1'b0;
        s_rty_n = 0; s_rty_base = 0; cur_dat = 32'h0;
        rty_given = 0; cyc_cnt = 0; wr_hs = 0; done_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_cyc", {30'b0, cyc, stb}, 32'd0);
        chk("rst_we_done_err", {29'b0, we, done, err}, 32'd0);
        chk("rst_chmask", {24'b0, err_chmask}, 32'd0);
        chk("rst_adr_sel", {6'b0, adr, sel}, 32'd0);
        rst = 1'b0;

        // Four channels, zero-wait ack, lowest first.
        b = wr_log.size();
        send(8'hA5, 8'h10, 32'hDEADBEEF);
        wait_done("a5", 600);
        chk("a5_err", {31'b0, d_err}, 32'd0);
        chk("a5_chmask", {24'b0, d_mask}, 32'd0);
        chk("a5_nwrites", 32'(wr_log.size() - b), 32'd4);
        if (wr_log.size() - b == 4) begin
            chk("a5_adr0", 32'(wr_log[b]), 32'h010);
            chk("a5_adr1", 32'(wr_log[b+1]), 32'h210);
            chk("a5_adr2", 32'(wr_log[b+2]), 32'h510);
            chk("a5_adr3", 32'(wr_log[b+3]), 32'h710);
            chk("a5_dat3", wr_dat_log[b+3], 32'hDEADBEEF);
        end

        // Empty mask: done next cycle, no bus activity.
        c0 = cyc_cnt;
        send(8'h00, 8'h33, 32'h12345678);
        chk("m0_done_next", {31'b0, done}, 32'd1);
        wait_done("m0", 4);
        chk("m0_err", {31'b0, d_err}, 32'd0);
        chk("m0_no_cyc", 32'(cyc_cnt - c0), 32'd0);

        // Error on ch1, ch2 still written.
        s_err_ch = 8'h02;
        b = wr_log.size();
        send(8'h06, 8'h10, 32'hA5A5_0001);
        wait_done("e06", 600);
        s_err_ch = 8'h00;
        chk("e06_err", {31'b0, d_err}, 32'd1);
        chk("e06_chmask", {24'b0, d_mask}, 32'h02);
        chk("e06_nwrites", 32'(wr_log.size() - b), 32'd2);
        if (wr_log.size() - b == 2) begin
            chk("e06_adr1", 32'(wr_log[b+1]), 32'h210);
        end

        // Silent target: cyc held for exactly TIMEOUT cycles.
        s_silent = 1'b1;
        c0 = cyc_cnt;
        send(8'h01, 8'h04, 32'h0000_0042);
        wait_done("tmo", 600);
        s_silent = 1'b0;
        chk("tmo_cyc_cycles", 32'(cyc_cnt - c0), 32'd255);
        chk("tmo_chmask", {24'b0, d_mask}, 32'h01);
        chk("tmo_err", {31'b0, d_err}, 32'd1);

        // Three rty then ack: success after four write cycles.
        s_rty_base = rty_given;
        s_rty_n = 3;
        h0 = wr_hs;
        send(8'h01, 8'h20, 32'hCAFE_0003);
        wait_done("rty3", 600);
        chk("rty3_hs", 32'(wr_hs - h0), 32'd4);
        chk("rty3_err", {31'b0, d_err}, 32'd0);

        // Four rty exceeds the budget: failure.
        s_rty_base = rty_given;
        s_rty_n = 4;
        h0 = wr_hs;
        send(8'h01, 8'h20, 32'hCAFE_0004);
        wait_done("rty4", 600);
        s_rty_n = 0;
        chk("rty4_hs", 32'(wr_hs - h0), 32'd4);
        chk("rty4_chmask", {24'b0, d_mask}, 32'h01);

        // Reset while a write is outstanding.
        s_silent = 1'b1;
        send(8'h01, 8'h08, 32'h0BAD_0BAD);
        for (int i = 0; i < 10; i++) begin
            if (cyc) break;
            @(negedge clk);
        end
        chk("rst_mid_cyc_seen", {31'b0, cyc}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_cyc_low", {30'b0, cyc, stb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s_silent = 1'b0;
        n0 = done_cnt;
        #1;
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        repeat (10) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - n0), 32'd0);

`ifdef TRIG_CFG_READBACK_EN
        // Read-back of ch3 returns zero.
        s_bad_rd = 8'h08;
        send(8'h0F, 8'h10, 32'h1357_9BDF);
        wait_done("rb", 1200);
        s_bad_rd = 8'h00;
        chk("rb_chmask", {24'b0, d_mask}, 32'h08);
        chk("rb_err", {31'b0, d_err}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
